timer_stopwatch_core: RTL and testbench

Parametrised countdown timer and stopwatch with a lap-capture buffer. It counts centisecond ticks derived from the system clock by an internal prescaler. It is driven by single-cycle, already-debounced button pulses from the front-panel logic, and feeds the display formatter and the alarm sounder.

---
 rtl/timer_pkg.sv | 11 +
 rtl/timer_stopwatch_core_if.sv | 26 ++
 rtl/lap_fifo.sv | 46 ++++
 rtl/timer_stopwatch_core.sv | 78 +++++++
 tb/tb_timer_stopwatch_core.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and mode constants for the timer/stopwatch core
package timer_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } timer_state_t;
   localparam logic MODE_COUNTDOWN = 1'b0;
   localparam logic MODE_STOPWATCH = 1'b1;
endpackage

// File: rtl/timer_stopwatch_core_if.sv
// timer_stopwatch_core_if: front-panel controls and display/alarm/lap outputs of the timer core
interface timer_stopwatch_core_if #(
   parameter int COUNT_W   = 32,
   parameter int LAP_DEPTH = 8
);
   logic                           modeSelect;
   logic                           startStopPulse;
   logic                           splitResetPulse;
   logic [COUNT_W-1:0]             loadValue;
   logic                           lapPop;
   logic [COUNT_W-1:0]             countValue;
   logic [1:0]                     timerState;
   logic                           ringSound;
   logic                           lapValid;
   logic [COUNT_W-1:0]             lapData;
   logic [$clog2(LAP_DEPTH+1)-1:0] lapCount;
   logic                           lapOverflow;
   modport master (
      output modeSelect, startStopPulse, splitResetPulse, loadValue, lapPop,
      input  countValue, timerState, ringSound, lapValid, lapData, lapCount, lapOverflow
   );
   modport slave (
      input  modeSelect, startStopPulse, splitResetPulse, loadValue, lapPop,
      output countValue, timerState, ringSound, lapValid, lapData, lapCount, lapOverflow
   );
endinterface

// File: rtl/lap_fifo.sv
// lap_fifo: first-word fall-through lap buffer with flush and sticky overflow
module lap_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clockSignal,
   input  logic             resetN,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic [CW-1:0]    count,
   output logic             overflow
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic             pop_ok, push_ok;
   assign valid   = count != '0;
   assign pop_ok  = pop && valid;
   // a pop in the same cycle frees the slot a push into a full buffer needs
   assign push_ok = push && (count != CW'(DEPTH) || pop_ok);
   assign dout    = valid ? mem[rd_ptr] : '0;
   always_ff @(posedge clockSignal)
      if (push_ok && !flush) mem[wr_ptr] <= din;
   always_ff @(posedge clockSignal or negedge resetN)
      if (!resetN) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         rd_ptr   <= rd_ptr + AW'(pop_ok);
         wr_ptr   <= wr_ptr + AW'(push_ok);
         count    <= count + CW'(push_ok) - CW'(pop_ok);
         overflow <= overflow | (push && !push_ok);
      end
endmodule

// File: rtl/timer_stopwatch_core.sv
// timer_stopwatch_core: countdown timer / stopwatch on a prescaled tick, with optional lap capture.
// The lap buffer is built only when TIMER_LAP_BUFFER_EN is defined.
module timer_stopwatch_core
   import timer_pkg::*;
#(
   parameter int TICK_DIV  = 1000,
   parameter int COUNT_W   = 32,
   parameter int LAP_DEPTH = 8
) (
   input logic                   clockSignal,
   input logic                   resetN,
   timer_stopwatch_core_if.slave bus
);
   localparam int PW = $clog2(TICK_DIV);
   timer_state_t       state;
   logic               mode;
   logic [PW-1:0]      prescale;
   logic [COUNT_W-1:0] count, next_count;
   logic               tick, start_ok, expire;
   assign tick       = state == RUN && prescale == PW'(TICK_DIV - 1);
   assign start_ok   = bus.startStopPulse && !(bus.modeSelect == MODE_COUNTDOWN && bus.loadValue == '0);
   assign next_count = mode == MODE_STOPWATCH ? count + COUNT_W'(count != '1) : count - COUNT_W'(1);
   assign expire     = tick && mode == MODE_COUNTDOWN && count == COUNT_W'(1);
   always_ff @(posedge clockSignal or negedge resetN)
      if (!resetN) begin
         state    <= IDLE;
         mode     <= MODE_COUNTDOWN;
         prescale <= '0;
         count    <= '0;
      end else begin
         case (state)
            IDLE: if (start_ok) begin
               state    <= RUN;
               mode     <= bus.modeSelect;
               prescale <= '0;
               count    <= bus.modeSelect == MODE_STOPWATCH ? '0 : bus.loadValue;
            end
            RUN: begin
               prescale <= tick ? '0 : prescale + PW'(1);
               if (tick) count <= next_count;
               if (expire) state <= EXPIRED;
               else if (bus.startStopPulse) state <= PAUSE;
            end
            PAUSE: if (bus.startStopPulse) state <= RUN;
               else if (bus.splitResetPulse) begin
                  state <= IDLE;
                  count <= '0;
               end
            EXPIRED: if (bus.startStopPulse || bus.splitResetPulse) state <= IDLE;
         endcase
      end
   assign bus.countValue = count;
   assign bus.timerState = state;
   assign bus.ringSound  = state == EXPIRED;
`ifdef TIMER_LAP_BUFFER_EN
   logic lap_push, lap_flush;
   // lap captures the count as it stood before this edge's tick
   assign lap_push  = state == RUN && mode == MODE_STOPWATCH && bus.splitResetPulse && !bus.startStopPulse;
   assign lap_flush = state == PAUSE && bus.splitResetPulse && !bus.startStopPulse;
   lap_fifo #(.WIDTH(COUNT_W), .DEPTH(LAP_DEPTH)) u_lap (
      .clockSignal (clockSignal),
      .resetN      (resetN),
      .push        (lap_push),
      .pop         (bus.lapPop),
      .flush       (lap_flush),
      .din         (count),
      .dout        (bus.lapData),
      .valid       (bus.lapValid),
      .count       (bus.lapCount),
      .overflow    (bus.lapOverflow)
   );
`else
   assign bus.lapValid    = 1'b0;
   assign bus.lapData     = '0;
   assign bus.lapCount    = '0;
   assign bus.lapOverflow = 1'b0;
`endif
endmodule

// File: tb/tb_timer_stopwatch_core.sv
// tb_timer_stopwatch_core: scoreboard bench; the reference model tracks elapsed running cycles
// and a lap queue, and derives the count arithmetically from them.
module tb_timer_stopwatch_core;
   import timer_pkg::*;
   localparam int TD = 4, CW = 16, LD = 4;
   localparam int MAXC = 2 ** CW - 1;
`ifdef TIMER_LAP_BUFFER_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif
   typedef struct packed {
      logic [1:0]    state;
      logic [CW-1:0] count;
      logic          ring;
      logic          valid;
      logic [CW-1:0] data;
      logic [2:0]    cnt;
      logic          ovf;
   } snap_t;
   logic clockSignal = 1'b0;
   logic resetN = 1'b0;
   timer_stopwatch_core_if #(.COUNT_W(CW), .LAP_DEPTH(LD)) bus ();
   timer_stopwatch_core #(.TICK_DIV(TD), .COUNT_W(CW), .LAP_DEPTH(LD)) dut (
      .clockSignal (clockSignal),
      .resetN      (resetN),
      .bus         (bus)
   );
   always #5 clockSignal = ~clockSignal;
   int checks = 0, errors = 0;
   snap_t exp_q[$];
   int m_state = 0, m_run = 0, m_base = 0;
   bit m_mode = 1'b0, m_ovf = 1'b0;
   int laps[$];
   function int m_count();
      if (m_state == 0 || m_state == 3) return 0;
      if (m_mode) return (m_run / TD > MAXC) ? MAXC : m_run / TD;
      return m_base - m_run / TD;
   endfunction
   function snap_t m_snap();
      snap_t s;
      s.state = 2'(m_state);
      s.count = CW'(m_count());
      s.ring  = m_state == 3;
      s.valid = laps.size() > 0;
      s.data  = laps.size() > 0 ? CW'(laps[0]) : '0;
      s.cnt   = 3'(laps.size());
      s.ovf   = m_ovf;
      return s;
   endfunction
   task automatic m_reset();
      m_state = 0;
      m_run = 0;
      laps.delete();
      m_ovf = 1'b0;
   endtask
   task automatic m_edge();
      bit pop_ok, push, flush;
      int pv;
      if (!resetN) begin
         m_reset();
         return;
      end
      pop_ok = bus.lapPop && laps.size() > 0;
      push = 0;
      flush = 0;
      pv = 0;
      case (m_state)
         0: if (bus.startStopPulse && !(bus.modeSelect == 0 && bus.loadValue == 0)) begin
            m_state = 1;
            m_mode = bus.modeSelect;
            m_base = int'(bus.loadValue);
            m_run = 0;
         end
         1: begin
            pv = m_count();
            m_run++;
            if (!m_mode && m_count() == 0) m_state = 3;
            else if (bus.startStopPulse) m_state = 2;
            else if (bus.splitResetPulse && m_mode && LAP_EN) push = 1;
         end
         2: if (bus.startStopPulse) m_state = 1;
            else if (bus.splitResetPulse) begin
               m_state = 0;
               flush = 1;
            end
         default: if (bus.startStopPulse || bus.splitResetPulse) m_state = 0;
      endcase
      if (pop_ok) void'(laps.pop_front());
      if (push) begin
         if (laps.size() < LD) laps.push_back(pv);
         else m_ovf = 1'b1;
      end
      if (flush) begin
         laps.delete();
         m_ovf = 1'b0;
      end
   endtask
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic cmp_snap(string tag, snap_t e);
      check({tag, ".state"}, 32'(bus.timerState), 32'(e.state));
      check({tag, ".count"}, 32'(bus.countValue), 32'(e.count));
      check({tag, ".ring"}, 32'(bus.ringSound), 32'(e.ring));
      check({tag, ".lapValid"}, 32'(bus.lapValid), 32'(e.valid));
      check({tag, ".lapData"}, 32'(bus.lapData), 32'(e.data));
      check({tag, ".lapCount"}, 32'(bus.lapCount), 32'(e.cnt));
      check({tag, ".lapOverflow"}, 32'(bus.lapOverflow), 32'(e.ovf));
   endtask
   // monitor: compares the DUT against each expectation pushed for the preceding edge
   initial forever begin
      snap_t e;
      @(posedge clockSignal);
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cmp_snap("mon", e);
      end
   end
   task automatic cyc(input bit ss = 0, input bit sp = 0, input bit md = 0,
                      input logic [CW-1:0] ld = '0, input bit pp = 0);
      @(negedge clockSignal);
      bus.startStopPulse = ss;
      bus.splitResetPulse = sp;
      bus.modeSelect = md;
      bus.loadValue = ld;
      bus.lapPop = pp;
      @(posedge clockSignal);
      m_edge();
      exp_q.push_back(m_snap());
   endtask
   task automatic idle(input int n);
      repeat (n) cyc();
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      bus.startStopPulse = 0;
      bus.splitResetPulse = 0;
      bus.modeSelect = 0;
      bus.loadValue = '0;
      bus.lapPop = 0;
      repeat (3) @(posedge clockSignal);
      #1;
      cmp_snap("reset", '0);
      @(negedge clockSignal);
      resetN = 1'b1;
      // countdown from 3 expires 12 edges after start
      cyc(1, 0, MODE_COUNTDOWN, 3);
      idle(11);
      #3;
      check("cd_running", 32'(bus.timerState), 32'(RUN));
      check("cd_count1", 32'(bus.countValue), 1);
      cyc();
      #3;
      check("cd_expired", 32'(bus.timerState), 32'(EXPIRED));
      check("cd_zero", 32'(bus.countValue), 0);
      check("cd_ring", 32'(bus.ringSound), 1);
      cyc(1);
      #3;
      check("cd_back_idle", 32'(bus.timerState), 32'(IDLE));
      check("cd_ring_off", 32'(bus.ringSound), 0);
      // pause/resume keeps prescaler phase
      cyc(1, 0, MODE_STOPWATCH);
      idle(9);
      cyc(1);
      #3;
      check("pr_paused", 32'(bus.timerState), 32'(PAUSE));
      check("pr_count2", 32'(bus.countValue), 2);
      idle(20);
      #3;
      check("pr_held", 32'(bus.countValue), 2);
      cyc(1);
      idle(1);
      #3;
      check("pr_resume_wait", 32'(bus.countValue), 2);
      cyc();
      #3;
      check("pr_count3", 32'(bus.countValue), 3);
      cyc(1);
      cyc(0, 1);
      #3;
      check("pr_reset_idle", 32'(bus.timerState), 32'(IDLE));
      check("pr_reset_zero", 32'(bus.countValue), 0);
      // five laps into a four-entry buffer, then drain
      cyc(1, 0, MODE_STOPWATCH);
      idle(4);
      for (int k = 1; k <= 5; k++) begin
         cyc(0, 1);
         if (k < 5) idle(3);
      end
      #3;
      check("lap_count", 32'(bus.lapCount), LAP_EN ? 4 : 0);
      check("lap_ovf", 32'(bus.lapOverflow), 32'(LAP_EN));
      cyc(1);
      for (int k = 1; k <= 4; k++) begin
         #3;
         check("lap_data", 32'(bus.lapData), LAP_EN ? k : 0);
         cyc(0, 0, 0, 0, 1);
      end
      #3;
      check("lap_drained", 32'(bus.lapValid), 0);
      check("lap_ovf_sticky", 32'(bus.lapOverflow), 32'(LAP_EN));
      cyc(0, 1);
      #3;
      check("lap_flush_ovf", 32'(bus.lapOverflow), 0);
      // both pulses in RUN: pause wins, no lap
      cyc(1, 0, MODE_STOPWATCH);
      idle(5);
      cyc(1, 1);
      #3;
      check("prio_pause", 32'(bus.timerState), 32'(PAUSE));
      check("prio_nolap", 32'(bus.lapCount), 0);
      cyc(0, 1);
      // asynchronous reset mid-run
      cyc(1, 0, MODE_COUNTDOWN, 50);
      idle(7);
      @(negedge clockSignal);
      #2;
      resetN = 1'b0;
      m_reset();
      #1;
      cmp_snap("midreset", '0);
      cyc();
      cyc();
      @(negedge clockSignal);
      resetN = 1'b1;
      // zero preset is ignored
      cyc(1, 0, MODE_COUNTDOWN, 0);
      #3;
      check("zero_idle", 32'(bus.timerState), 32'(IDLE));
      check("zero_count", 32'(bus.countValue), 0);
      // randomized traffic against the model
      repeat (3000) begin
         logic [CW-1:0] ld;
         ld = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 12));
         cyc($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
             ld, $urandom_range(0, 3) == 0);
      end
      cyc();
      #5;
      check("drain", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
